// File: rtl/sap_pkg.sv
// Shared constants for the SAP-1 controller/sequencer: opcodes, control-word bit positions and width.
package sap_pkg;

    localparam int CW_WIDTH = 12;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam int CW_CP = 11;
    localparam int CW_EP = 10;
    localparam int CW_LM = 9;
    localparam int CW_CE = 8;
    localparam int CW_LI = 7;
    localparam int CW_EI = 6;
    localparam int CW_LA = 5;
    localparam int CW_EA = 4;
    localparam int CW_SU = 3;
    localparam int CW_EU = 2;
    localparam int CW_LB = 1;
    localparam int CW_LO = 0;

endpackage

// File: rtl/sap_ring_counter.sv
// One-hot T-state ring: rotates T1..T(RING_LEN) on each clock unless held; async reset to T1.
module sap_ring_counter #(
    parameter int RING_LEN = 6
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_hold,
    output logic [RING_LEN-1:0] o_tstate
);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_tstate <= {{(RING_LEN-1){1'b0}}, 1'b1};
        end else if (!i_hold) begin
            o_tstate <= {o_tstate[RING_LEN-2:0], o_tstate[RING_LEN-1]};
        end
    end

endmodule

// File: rtl/sap_controller_sequencer.sv
// SAP-1 controller/sequencer: ring counter plus control-word decode and halt flag.
// Optional single-step input when SAP_CTRL_SINGLE_STEP_EN is defined.
module sap_controller_sequencer
    import sap_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int RING_LEN = 6
) (
    input  logic                i_clk,
    input  logic                i_reset,
`ifdef SAP_CTRL_SINGLE_STEP_EN
    input  logic                i_step,
`endif
    input  logic [OPCODE_W-1:0] i_opcode,
    output logic [CW_WIDTH-1:0] o_ctrl,
    output logic [RING_LEN-1:0] o_tstate,
    output logic                o_halt
);

    logic                halted;
    logic                halt_now;
    logic                advance;
    logic [RING_LEN-1:0] tstate;
    logic [CW_WIDTH-1:0] ctrl;
    logic [4:0]          bus_en;

`ifdef SAP_CTRL_SINGLE_STEP_EN
    logic [1:0] step_sync;
    logic       step_prev;

    // Two-flop synchroniser on the asynchronous step button, then a rising-edge detect.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            step_sync <= 2'b00;
            step_prev <= 1'b0;
        end else begin
            step_sync <= {step_sync[0], i_step};
            step_prev <= step_sync[1];
        end
    end

    assign advance = step_sync[1] & ~step_prev;
`else
    assign advance = 1'b1;
`endif

    // HLT is recognised at the T4 edge regardless of stepping and freezes the ring in T4.
    assign halt_now = tstate[3] && (i_opcode == OPCODE_W'(OP_HLT)) && !halted;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            halted <= 1'b0;
        end else if (halt_now) begin
            halted <= 1'b1;
        end
    end

    sap_ring_counter #(
        .RING_LEN (RING_LEN)
    ) u_ring (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_hold   (halted | halt_now | ~advance),
        .o_tstate (tstate)
    );

    always_comb begin
        ctrl = '0;
        if (!i_reset && !halted) begin
            if (tstate[0]) begin
                ctrl[CW_EP] = 1'b1;
                ctrl[CW_LM] = 1'b1;
            end
            if (tstate[1]) begin
                ctrl[CW_CP] = 1'b1;
            end
            if (tstate[2]) begin
                ctrl[CW_CE] = 1'b1;
                ctrl[CW_LI] = 1'b1;
            end
            if (tstate[3]) begin
                case (i_opcode)
                    OPCODE_W'(OP_LDA), OPCODE_W'(OP_ADD), OPCODE_W'(OP_SUB): begin
                        ctrl[CW_EI] = 1'b1;
                        ctrl[CW_LM] = 1'b1;
                    end
                    OPCODE_W'(OP_OUT): begin
                        ctrl[CW_EA] = 1'b1;
                        ctrl[CW_LO] = 1'b1;
                    end
                    default: ;
                endcase
            end
            if (tstate[4]) begin
                case (i_opcode)
                    OPCODE_W'(OP_LDA): begin
                        ctrl[CW_CE] = 1'b1;
                        ctrl[CW_LA] = 1'b1;
                    end
                    OPCODE_W'(OP_ADD), OPCODE_W'(OP_SUB): begin
                        ctrl[CW_CE] = 1'b1;
                        ctrl[CW_LB] = 1'b1;
                    end
                    default: ;
                endcase
            end
            if (tstate[5]) begin
                case (i_opcode)
                    OPCODE_W'(OP_ADD): begin
                        ctrl[CW_EU] = 1'b1;
                        ctrl[CW_LA] = 1'b1;
                    end
                    OPCODE_W'(OP_SUB): begin
                        ctrl[CW_SU] = 1'b1;
                        ctrl[CW_EU] = 1'b1;
                        ctrl[CW_LA] = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_ctrl   = ctrl;
    assign o_tstate = tstate;
    assign o_halt   = halted;

    // Only one driver may own the shared 8-bit bus in any T-state.
    assign bus_en = {ctrl[CW_EP], ctrl[CW_CE], ctrl[CW_EI], ctrl[CW_EA], ctrl[CW_EU]};

    bus_single_driver: assert property (@(posedge i_clk) disable iff (i_reset) $onehot0(bus_en));

endmodule

// File: tb/tb_sap_controller_sequencer.sv
// Self-checking bench for sap_controller_sequencer against a T-state/opcode reference table.
// Also covers the SAP_CTRL_SINGLE_STEP_EN build when that macro is defined.
module tb_sap_controller_sequencer;

    localparam int RL = 6;

    localparam logic [11:0] B_CP = 12'h800;
    localparam logic [11:0] B_EP = 12'h400;
    localparam logic [11:0] B_LM = 12'h200;
    localparam logic [11:0] B_CE = 12'h100;
    localparam logic [11:0] B_LI = 12'h080;
    localparam logic [11:0] B_EI = 12'h040;
    localparam logic [11:0] B_LA = 12'h020;
    localparam logic [11:0] B_EA = 12'h010;
    localparam logic [11:0] B_SU = 12'h008;
    localparam logic [11:0] B_EU = 12'h004;
    localparam logic [11:0] B_LB = 12'h002;
    localparam logic [11:0] B_LO = 12'h001;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  opcode;
    logic [11:0] o_ctrl;
    logic [5:0]  o_tstate;
    logic        o_halt;
`ifdef SAP_CTRL_SINGLE_STEP_EN
    logic        step;
`endif

    int total = 0;
    int bad   = 0;
    int mt    = 0;
    bit mh    = 1'b0;
    bit mrst  = 1'b1;

    sap_controller_sequencer #(
        .OPCODE_W (4),
        .RING_LEN (RL)
    ) dut (
        .i_clk    (clk),
        .i_reset  (reset),
`ifdef SAP_CTRL_SINGLE_STEP_EN
        .i_step   (step),
`endif
        .i_opcode (opcode),
        .o_ctrl   (o_ctrl),
        .o_tstate (o_tstate),
        .o_halt   (o_halt)
    );

    always #5 clk = ~clk;

    // Reference micro-program: T-state index (0 = T1) and opcode to the expected control word.
    function automatic logic [11:0] expCtrl(input int t, input logic [3:0] op, input bit h, input bit r);
        logic [11:0] w;
        w = '0;
        if (!r && !h) begin
            case (t)
                0: w = B_EP | B_LM;
                1: w = B_CP;
                2: w = B_CE | B_LI;
                3: if (op == 4'h0 || op == 4'h1 || op == 4'h2) w = B_EI | B_LM;
                   else if (op == 4'hE) w = B_EA | B_LO;
                4: if (op == 4'h0) w = B_CE | B_LA;
                   else if (op == 4'h1 || op == 4'h2) w = B_CE | B_LB;
                5: if (op == 4'h1) w = B_EU | B_LA;
                   else if (op == 4'h2) w = B_SU | B_EU | B_LA;
                default: w = '0;
            endcase
        end
        return w;
    endfunction

    task automatic modelStep();
        if (!mh) begin
            if (mt == 3 && opcode == 4'hF) mh = 1'b1;
            else mt = (mt + 1) % RL;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One sequencer step: a plain clock, or a full step-button pulse in single-step builds.
    task automatic applyStimulus();
`ifdef SAP_CTRL_SINGLE_STEP_EN
        if (!mh && mt == 3 && opcode == 4'hF) begin
            tick();
            modelStep();
        end else begin
            step = 1'b1;
            tick();
            tick();
            step = 1'b0;
            tick();
            modelStep();
            tick();
            tick();
        end
`else
        tick();
        modelStep();
`endif
    endtask

    task automatic checkOutput(input string tag);
        logic [11:0] ec;
        logic [5:0]  et;
        logic        eh;
        ec = expCtrl(mt, opcode, mh, mrst);
        et = 6'(1) << mt;
        eh = mh && !mrst;
        total++;
        assert (o_ctrl === ec) else begin
            bad++;
            $error("[TB] FAIL %s ctrl observed=%h expected=%h", tag, o_ctrl, ec);
        end
        total++;
        assert (o_tstate === et) else begin
            bad++;
            $error("[TB] FAIL %s tstate observed=%b expected=%b", tag, o_tstate, et);
        end
        total++;
        assert (o_halt === eh) else begin
            bad++;
            $error("[TB] FAIL %s halt observed=%b expected=%b", tag, o_halt, eh);
        end
    endtask

    task automatic runInstruction(input logic [3:0] op, input string tag);
        opcode = op;
        for (int i = 0; i < RL; i++) begin
            applyStimulus();
            checkOutput(tag);
        end
    endtask

    initial begin
        logic [3:0] dirOps [5];
        dirOps = '{4'h0, 4'h1, 4'h2, 4'hE, 4'h7};
        reset  = 1'b1;
        opcode = 4'h0;
`ifdef SAP_CTRL_SINGLE_STEP_EN
        step   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_hold");
        reset = 1'b0;
        mrst  = 1'b0;
        #1;
        checkOutput("reset_release");

        foreach (dirOps[k]) runInstruction(dirOps[k], "directed");

        for (int n = 0; n < 25; n++) begin
            runInstruction(4'($urandom_range(0, 14)), "random");
        end

        // Abort mid-T5: reset returns to T1 immediately.
        opcode = 4'h1;
        repeat (4) begin
            applyStimulus();
            checkOutput("pre_abort");
        end
        #2;
        reset = 1'b1;
        mrst  = 1'b1;
        mt    = 0;
        mh    = 1'b0;
        #1;
        checkOutput("reset_mid_t5");
        tick();
        checkOutput("reset_mid_hold");
        reset = 1'b0;
        mrst  = 1'b0;
        #1;
        checkOutput("reset_mid_release");

        runInstruction(4'hE, "out");

        opcode = 4'hF;
        repeat (3) begin
            applyStimulus();
            checkOutput("hlt_fetch");
        end
        checkOutput("hlt_t4");
        for (int i = 0; i < 20; i++) begin
            applyStimulus();
            checkOutput("halted");
        end

        reset = 1'b1;
        mrst  = 1'b1;
        mt    = 0;
        mh    = 1'b0;
        #1;
        checkOutput("halt_reset");
        tick();
        reset  = 1'b0;
        mrst   = 1'b0;
        opcode = 4'h2;
        #1;
        checkOutput("halt_cleared");
        runInstruction(4'h2, "after_halt");

`ifdef SAP_CTRL_SINGLE_STEP_EN
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("no_step_hold");
        end
        step = 1'b1;
        tick();
        checkOutput("step_sync1");
        tick();
        checkOutput("step_sync2");
        step = 1'b0;
        tick();
        modelStep();
        checkOutput("step_advance");
        repeat (3) begin
            tick();
            checkOutput("step_once");
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
